// File: rtl/ksa_swap_fsm_if.sv
// ksa_swap_fsm_if: bundles the handshake and S-memory signals of the RC4 KSA swap stage.
//   start      : request a key-scheduling pass (controller -> stage)
//   secret_key : key bytes, byte 0 in the most significant byte
//   rd_data    : S-memory read data (memory -> stage)
//   mem_addr   : S-memory address (stage -> memory)
//   wr_data    : S-memory write data
//   wr_en      : S-memory write enable
//   busy       : pass in progress
//   finish     : one-cycle pulse when the pass completes
// The slave modport is the swap stage. The master modport is the controller/memory side.
interface ksa_swap_fsm_if #(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned DATA_W    = 8
);
  logic                          start;
  logic [DATA_W*KEY_BYTES-1:0]   secret_key;
  logic [DATA_W-1:0]             rd_data;
  logic [DATA_W-1:0]             mem_addr;
  logic [DATA_W-1:0]             wr_data;
  logic                          wr_en;
  logic                          busy;
  logic                          finish;

  modport master (
    output start, secret_key, rd_data,
    input  mem_addr, wr_data, wr_en, busy, finish
  );

  modport slave (
    input  start, secret_key, rd_data,
    output mem_addr, wr_data, wr_en, busy, finish
  );
endinterface

// File: rtl/ksa_swap_fsm.sv
// ksa_swap_fsm: RC4 key-scheduling swap pass over a 256-entry S array.
// For i = 0..255: j += S[i] + key[i mod KEY_BYTES], then swap S[i] and S[j]. Each
// iteration takes 7 cycles: read S[i], capture, read S[j], capture, two writes, advance.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset; aborts a pass in progress
//   bus : ksa_swap_fsm_if slave (start/secret_key/rd_data in; mem_addr/wr_data/wr_en/
//         busy/finish out)
// All outputs are decoded from state and registers only. No path runs from rd_data to an
// output.
module ksa_swap_fsm #(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned DATA_W    = 8
) (
  input logic            clk,
  input logic            rst,
  ksa_swap_fsm_if.slave  bus
);

  localparam int unsigned KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  typedef enum logic [3:0] {
    StIdle,
    StRdSi,
    StGetSi,
    StRdSj,
    StGetSj,
    StWrSi,
    StWrSj,
    StNext,
    StDone
  } state_e;

  state_e              r_state, w_state_d;
  logic [DATA_W-1:0]   r_i, w_i_d;
  logic [DATA_W-1:0]   r_j, w_j_d;
  logic [DATA_W-1:0]   r_si, w_si_d;
  logic [DATA_W-1:0]   r_sj, w_sj_d;
  logic [KIDX_W-1:0]   r_kidx, w_kidx_d;
  logic [DATA_W-1:0]   w_key_byte;

  // Key byte 0 sits in the top byte of secret_key.
  always_comb begin
    w_key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (r_kidx == KIDX_W'(k)) begin
        w_key_byte = bus.secret_key[DATA_W*(KEY_BYTES-1-k) +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_i     <= '0;
      r_j     <= '0;
      r_si    <= '0;
      r_sj    <= '0;
      r_kidx  <= '0;
    end else begin
      r_state <= w_state_d;
      r_i     <= w_i_d;
      r_j     <= w_j_d;
      r_si    <= w_si_d;
      r_sj    <= w_sj_d;
      r_kidx  <= w_kidx_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_i_d        = r_i;
    w_j_d        = r_j;
    w_si_d       = r_si;
    w_sj_d       = r_sj;
    w_kidx_d     = r_kidx;
    bus.mem_addr = r_i;
    bus.wr_data  = '0;
    bus.wr_en    = 1'b0;
    bus.busy     = 1'b1;
    bus.finish   = 1'b0;

    unique case (r_state)
      StIdle: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          w_i_d     = '0;
          w_j_d     = '0;
          w_kidx_d  = '0;
          w_state_d = StRdSi;
        end
      end
      StRdSi: begin
        w_state_d = StGetSi;
      end
      StGetSi: begin
        w_si_d    = bus.rd_data;
        w_j_d     = r_j + bus.rd_data + w_key_byte;
        w_state_d = StRdSj;
      end
      StRdSj: begin
        bus.mem_addr = r_j;
        w_state_d    = StGetSj;
      end
      StGetSj: begin
        w_sj_d    = bus.rd_data;
        w_state_d = StWrSi;
      end
      StWrSi: begin
        bus.wr_data = r_sj;
        bus.wr_en   = 1'b1;
        w_state_d   = StWrSj;
      end
      StWrSj: begin
        bus.mem_addr = r_j;
        bus.wr_data  = r_si;
        bus.wr_en    = 1'b1;
        w_state_d    = StNext;
      end
      StNext: begin
        w_i_d    = r_i + DATA_W'(1);
        w_kidx_d = (r_kidx == KIDX_W'(KEY_BYTES - 1)) ? '0 : r_kidx + KIDX_W'(1);
        // r_i still holds the index just finished; all-ones means this was the last one.
        w_state_d = (r_i == '1) ? StDone : StRdSi;
      end
      StDone: begin
        bus.busy   = 1'b0;
        bus.finish = 1'b1;
        w_state_d  = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// tb_ksa_swap_fsm: scoreboard bench for ksa_swap_fsm. Stimulus pushes the expected write
// trace, finish time and final S contents. A monitor on the falling edge pops and compares.
module tb_ksa_swap_fsm;

  localparam int KB  = 3;
  localparam int PER = 10;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;
  typedef logic [7:0] b10_t [10];

  logic clk;
  logic rst;
  logic init_mem;

  ksa_swap_fsm_if #(.KEY_BYTES(KB), .DATA_W(8)) bus ();

  ksa_swap_fsm #(.KEY_BYTES(KB), .DATA_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #(PER/2) clk = ~clk;

  // Single-port synchronous S memory with an "init stage" that fills S[k] = k.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (bus.wr_en) begin
      mem[bus.mem_addr] <= bus.wr_data;
    end
    bus.rd_data <= mem[bus.mem_addr];
  end

  logic rst_seen;
  always @(posedge clk) rst_seen <= rst;

  // Scoreboard state
  wr_t        wq[$];
  longint     fin_q[$];
  logic [7:0] exp_s [256];
  bit         chk_s;
  bit         end_req;
  bit         end_ack;
  int         n_cmp;
  int         n_bad;

  // Software model outputs
  logic [7:0] model_wa [512];
  logic [7:0] model_wd [512];
  logic [7:0] model_s  [256];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  initial begin
    int  busy_cnt;
    int  wr_cnt;
    bit  wd_fired;
    wr_t e;
    n_cmp    = 0;
    n_bad    = 0;
    end_ack  = 1'b0;
    busy_cnt = 0;
    wr_cnt   = 0;
    wd_fired = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_seen) begin
        chk("reset_outputs", {40'd0, bus.mem_addr, bus.wr_data, 5'd0, bus.wr_en, bus.busy,
            bus.finish}, 64'd0);
        busy_cnt = 0;
        wr_cnt   = 0;
      end
      if (bus.wr_en === 1'b1) begin
        wr_cnt++;
        if (wq.size() == 0) begin
          chk("unexpected_write", {48'd0, bus.mem_addr, bus.wr_data}, 64'hdead);
        end else begin
          e = wq.pop_front();
          chk("write", {48'd0, bus.mem_addr, bus.wr_data}, {48'd0, e.a, e.d});
        end
      end
      if (bus.busy === 1'b1) busy_cnt++;
      if (busy_cnt > 1800 && !wd_fired) begin
        wd_fired = 1'b1;
        chk("busy_watchdog", 64'(busy_cnt), 64'd1792);
      end
      if (bus.finish === 1'b1) begin
        if (fin_q.size() == 0) begin
          chk("unexpected_finish", 64'($time), 64'd0);
        end else begin
          chk("finish_time", 64'($time), 64'(fin_q.pop_front()));
          chk("busy_cycles", 64'(busy_cnt), 64'd1792);
          chk("write_count", 64'(wr_cnt), 64'd512);
          if (chk_s) begin
            int  bad_k;
            bit  seen [256];
            int  dup;
            bad_k = -1;
            dup   = 0;
            for (int k = 0; k < 256; k++) seen[k] = 1'b0;
            for (int k = 0; k < 256; k++) begin
              if (mem[k] !== exp_s[k] && bad_k < 0) bad_k = k;
              if (seen[mem[k]]) dup++;
              seen[mem[k]] = 1'b1;
            end
            if (bad_k < 0) chk("final_s", 64'd0, 64'd0 + 64'(bad_k + 1));
            else chk("final_s", {48'd0, 8'(bad_k), mem[bad_k]}, {48'd0, 8'(bad_k), exp_s[bad_k]});
            chk("s_permutation_dups", 64'(dup), 64'd0);
          end
        end
        busy_cnt = 0;
        wr_cnt   = 0;
        wd_fired = 1'b0;
      end
      if (end_req && !end_ack) begin
        chk("pending_writes", 64'(wq.size()), 64'd0);
        chk("pending_finish", 64'(fin_q.size()), 64'd0);
        end_ack = 1'b1;
      end
    end
  end

  // Software RC4 KSA over identity S; records the 512-write trace and final S.
  task automatic run_model(input logic [8*KB-1:0] key);
    logic [7:0] s [256];
    logic [7:0] j;
    logic [7:0] t;
    logic [7:0] kb;
    j = 8'd0;
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    for (int i = 0; i < 256; i++) begin
      kb = key[8*(KB-1-(i%KB)) +: 8];
      j = 8'(j + s[i] + kb);
      t = s[i];
      model_wa[2*i]   = 8'(i);
      model_wd[2*i]   = s[j];
      model_wa[2*i+1] = j;
      model_wd[2*i+1] = t;
      s[i] = s[j];
      s[j] = t;
    end
    for (int k = 0; k < 256; k++) model_s[k] = s[k];
  endtask

  // Queue expectations, run the init stage, then pulse start. Returns at the falling edge
  // after the accepting edge E0.
  task automatic start_pass(input logic [8*KB-1:0] key, input int n_push, input int hand_n,
                            input b10_t ha, input b10_t hd, input bit chk_final);
    longint t0;
    run_model(key);
    for (int w = 0; w < n_push; w++) begin
      if (w < hand_n) wq.push_back('{a: ha[w], d: hd[w]});
      else wq.push_back('{a: model_wa[w], d: model_wd[w]});
    end
    for (int k = 0; k < 256; k++) exp_s[k] = model_s[k];
    chk_s = chk_final;
    bus.secret_key = key;
    @(negedge clk);
    init_mem = 1'b1;
    @(negedge clk);
    init_mem = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    t0 = longint'($time);
    if (n_push == 512) fin_q.push_back(t0 + 1793 * PER - PER / 2);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Stimulus
  initial begin
    b10_t ha;
    b10_t hd;
    b10_t none;
    for (int k = 0; k < 10; k++) none[k] = 8'd0;
    rst            = 1'b1;
    init_mem       = 1'b0;
    end_req        = 1'b0;
    chk_s          = 1'b0;
    bus.start      = 1'b0;
    bus.secret_key = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // Key 0: hand trace for iterations 0..3.
    ha = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd5, 8'd0, 8'd0};
    hd = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd3, 8'd2, 8'd5, 8'd2, 8'd0, 8'd0};
    start_pass(24'h000000, 512, 8, ha, hd, 1'b1);
    repeat (1800) @(posedge clk);

    // Key 0x000249 with a stray start pulse at cycle 50 that must be ignored.
    start_pass(24'h000249, 512, 0, none, none, 1'b1);
    repeat (48) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (1800) @(posedge clk);

    // Key wrap: bytes 01,02,03,01,02 give j = 1,3,8,9,15 for i = 0..4.
    ha = '{8'd0, 8'd1, 8'd1, 8'd3, 8'd2, 8'd8, 8'd3, 8'd9, 8'd4, 8'd15};
    hd = '{8'd1, 8'd0, 8'd3, 8'd0, 8'd8, 8'd2, 8'd9, 8'd0, 8'd15, 8'd4};
    start_pass(24'h010203, 512, 10, ha, hd, 1'b1);
    repeat (1800) @(posedge clk);

    // Abort at iteration 100 (GET_SJ), reset held 2 cycles with start high.
    start_pass(24'h000249, 200, 0, none, none, 1'b0);
    repeat (702) @(posedge clk);
    @(negedge clk);
    rst       = 1'b1;
    bus.start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);

    // Restart after re-init: must match an uninterrupted pass.
    start_pass(24'h000249, 512, 0, none, none, 1'b1);
    repeat (1800) @(posedge clk);

    end_req = 1'b1;
    repeat (3) @(posedge clk);
    if (!end_ack) begin
      n_bad++;
      $display("FAIL end_handshake: got 0, want 1");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
